result_matrix_collector: RTL
============================

Name: result_matrix_collector

Overview:
- Downstream of sequential_matrix_multiplier: consumes its per-element result handshake (z_out/z_i/z_j/z_stb/z_ack) and assembles the m x m result matrix in an internal buffer.
- Once every element has arrived, streams the matrix out row-major over a valid/ready port to the file writer or the next stage.
- Replaces the behavioural result capture in the multiplier benches and becomes the synthesizable result sink.

Parameters:
- M, 4, matrix dimension; power of 2, at least 2.
- W, 32, element width in bits.
- IW, $clog2(M), row/column index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; 0 = reset.
- clear  input  1  synchronous restart for a new matrix; discards collection state.
- z_out  input  W  result element from the multiplier.
- z_i  input  IW  row index of z_out.
- z_j  input  IW  column index of z_out.
- z_stb  input  1  element valid strobe from the multiplier.
- z_ack  output  1  one-cycle acknowledge of an accepted element.
- full  output  1  all M*M elements collected.
- dup_err  output  1  sticky: an element index was written twice.
- rd_valid  output  1  read-out element valid.
- rd_ready  input  1  consumer accepts the read-out element.
- rd_data  output  W  read-out element value.
- rd_i  output  IW  read-out row index.
- rd_j  output  IW  read-out column index.
- rd_last  output  1  asserted with element (M-1,M-1).
- done  output  1  full matrix drained; held until clear or reset.

Behaviour:
- Reset (rst=0, async):
  - State = COLLECT; count and filled bitmap cleared.
  - z_ack, full, dup_err, rd_valid, rd_last, done = 0.
  - rd_data, rd_i, rd_j = 0.
  - Buffer contents are not reset.
- State COLLECT:
  - Element acceptance: at a rising edge with z_stb=1 and z_ack=0, write z_out into buf[z_i][z_j] and register z_ack=1 for exactly the next cycle.
  - While z_ack=1, z_stb is ignored (no double capture of a held strobe). Maximum rate is one element per 2 cycles.
  - First write to an index: set the filled bit and increment count (width clog2(M*M)+1).
  - Repeat write to a filled index: overwrite the buffer, set dup_err (sticky until clear/reset), do not increment count, still ack.
  - Transition: when count reaches M*M, assert full on the following cycle and go to DRAIN. full stays 1 until clear/reset.
- State DRAIN:
  - Pointer (ri, rj) starts at (0,0). rd_valid rises one cycle after entry (registered buffer read).
  - rd_data, rd_i, rd_j, rd_last stay stable while rd_valid=1 and rd_ready=0.
  - Transfer occurs on a cycle with rd_valid=1 and rd_ready=1. The pointer advances row-major (rj wraps to 0, ri increments), and the next element is presented the very next cycle, so back-to-back transfers are possible.
  - rd_ready with rd_valid=0 has no effect.
  - z_stb in DRAIN is not acked and does not write the buffer.
  - Transition: the transfer with rd_last=1 moves to DONE; rd_valid drops the next cycle.
- State DONE:
  - done = 1; rd_valid = 0; z_stb is ignored.
- clear (synchronous, any state, priority over all other actions):
  - Next state COLLECT; count and bitmap cleared.
  - full, dup_err, done, rd_valid, z_ack = 0.
  - If z_stb=1 in the same cycle as clear, the element is not captured.
- Reset mid-operation: drops immediately to reset values; partial collection is lost.

Test Plan:
1. Reset, then 16 elements in order (i,j) with z_out=10*i+j, z_stb held until z_ack each time, then rd_ready=1 -> z_ack is exactly 1 cycle per element; full=1 one cycle after the 16th ack; the stream is 0,1,2,3,10,...,33 with rd_i/rd_j matching; rd_last only on 33; done=1; dup_err=0.
2. Elements in random index order, z_stb held high continuously -> each element captured exactly once; the stream is row-major and correct regardless of arrival order.
3. Index (1,2) written twice (values 5 then 7) plus the 15 remaining indices -> dup_err=1 after the second write; full only after all 16 distinct indices; rd_data at (1,2)=7.
4. During DRAIN, rd_ready toggles 1,0,0,1 -> outputs stable across the stall; no element skipped or repeated; z_stb pulse in DRAIN is not acked.
5. clear asserted after 9 accepts together with z_stb=1 -> no ack that cycle; count=0, full=0; a full 16-element load afterwards completes normally.
6. rst=0 asserted asynchronously mid-DRAIN -> rd_valid, done, full, z_ack drop to 0 without waiting for a clock edge; the block restarts in COLLECT.

Source files
------------

// File: rtl/result_matrix_collector.sv
// Result sink for the sequential matrix multiplier: gathers M x M elements through the
// z_stb/z_ack handshake, then streams the matrix out row-major on a valid/ready port.
module result_matrix_collector #(
    parameter int unsigned M  = 4,
    parameter int unsigned W  = 32,
    parameter int unsigned IW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [W-1:0]  z_out,
    input  logic [IW-1:0] z_i,
    input  logic [IW-1:0] z_j,
    input  logic          z_stb,
    output logic          z_ack,
    output logic          full,
    output logic          dup_err,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [W-1:0]  rd_data,
    output logic [IW-1:0] rd_i,
    output logic [IW-1:0] rd_j,
    output logic          rd_last,
    output logic          done
);

    localparam int unsigned N  = M * M;
    localparam int unsigned AW = 2 * IW;
    localparam int unsigned CW = $clog2(N) + 1;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [W-1:0]  mem [N];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  filled_q, filled_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          z_ack_q, z_ack_d;
    logic          full_q, full_d;
    logic          dup_err_q, dup_err_d;
    logic          rd_valid_q, rd_valid_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          rd_last_q, rd_last_d;
    logic          done_q, done_d;

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] ptr_nxt;
    logic          collected;
    logic          accept;

    assign wr_addr   = {z_i, z_j};
    assign ptr_nxt   = ptr_q + 1'b1;
    assign collected = (count_q == CW'(N));
    // A held strobe is not recaptured while its ack is still high.
    assign accept    = !clear && (state_q == COLLECT) && !collected && z_stb && !z_ack_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        filled_d   = filled_q;
        ptr_d      = ptr_q;
        z_ack_d    = 1'b0;
        full_d     = full_q;
        dup_err_d  = dup_err_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        done_d     = done_q;

        if (clear) begin
            state_d    = COLLECT;
            count_d    = '0;
            filled_d   = '0;
            ptr_d      = '0;
            full_d     = 1'b0;
            dup_err_d  = 1'b0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (collected) begin
                        full_d  = 1'b1;
                        ptr_d   = '0;
                        state_d = DRAIN;
                    end else if (accept) begin
                        z_ack_d = 1'b1;
                        if (filled_q[wr_addr]) begin
                            dup_err_d = 1'b1;
                        end else begin
                            filled_d[wr_addr] = 1'b1;
                            count_d           = count_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!rd_valid_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem[ptr_q];
                        rd_last_d  = (ptr_q == AW'(N - 1));
                    end else if (rd_ready) begin
                        if (rd_last_q) begin
                            rd_valid_d = 1'b0;
                            rd_last_d  = 1'b0;
                            done_d     = 1'b1;
                            state_d    = DONE;
                        end else begin
                            // Present the next element straight away for back-to-back transfers.
                            ptr_d     = ptr_nxt;
                            rd_data_d = mem[ptr_nxt];
                            rd_last_d = (ptr_nxt == AW'(N - 1));
                        end
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            filled_q   <= '0;
            ptr_q      <= '0;
            z_ack_q    <= 1'b0;
            full_q     <= 1'b0;
            dup_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            filled_q   <= filled_d;
            ptr_q      <= ptr_d;
            z_ack_q    <= z_ack_d;
            full_q     <= full_d;
            dup_err_q  <= dup_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
        end
    end

    // Matrix storage has no reset; contents are only meaningful once full.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= z_out;
        end
    end

    assign z_ack    = z_ack_q;
    assign full     = full_q;
    assign dup_err  = dup_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_i     = ptr_q[AW-1:IW];
    assign rd_j     = ptr_q[IW-1:0];
    assign rd_last  = rd_last_q;
    assign done     = done_q;

endmodule
